// File: rtl/uart_pkg.sv
// Shared definitions for the auto-baud controller.
//   ab_state_e       : measurement FSM states
//   SYNC_EDGES       : falling edges in one 0x55 sync character (8N1)
//   OVERSAMPLE_SHIFT : log2(8 bit-times * 16x oversample)
//   ROUND_ADD        : half of 2^OVERSAMPLE_SHIFT, rounds the divide to nearest
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_IDLE,
    ST_WAIT_EDGE,
    ST_MEASURE,
    ST_CALC
  } ab_state_e;

  localparam int unsigned SYNC_EDGES       = 5;
  localparam int unsigned OVERSAMPLE_SHIFT = 7;
  localparam int unsigned ROUND_ADD        = 64;

endpackage

// File: rtl/baud_tick_prog.sv
// Programmable 16x-oversample tick generator.
//   clock     : system clock
//   reset_n   : asynchronous active-low reset
//   divisor   : tick period minus one, in clocks
//   load      : a new divisor is being loaded; restarts the count at 0
//   baud_rate : registered one-clock tick, one every divisor+1 clocks
module baud_tick_prog
  import uart_pkg::*;
#(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [DIV_W-1:0] divisor,
  input  logic             load,
  output logic             baud_rate
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  always_comb begin
    cnt_d  = cnt_q + DIV_W'(1);
    tick_d = 1'b0;
    if (load) begin
      // Restarting at 0 gives a full divisor+1 period before the first new tick.
      cnt_d = '0;
    end else if (cnt_q >= divisor) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign baud_rate = tick_q;

endmodule

// File: rtl/autobaud_ctrl.sv
// Auto-baud controller: on start, measures one 0x55 sync character on rx,
// derives the 16x-oversample tick divisor and switches the tick generator to it.
//   clock     : system clock
//   reset_n   : asynchronous active-low reset
//   rx        : raw serial line (idle high, asynchronous)
//   start     : one-cycle request to begin auto-baud (ignored while busy)
//   busy      : measurement in progress
//   locked    : divisor holds a measured value
//   error     : one-cycle pulse on measurement failure
//   divisor   : divisor in use by the tick generator
//   baud_rate : one-clock tick every divisor+1 clocks
module autobaud_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned DEFAULT_DIV = 163,
  parameter int unsigned MIN_PULSE   = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             rx,
  input  logic             start,
  output logic             busy,
  output logic             locked,
  output logic             error,
  output logic [DIV_W-1:0] divisor,
  output logic             baud_rate
);

  localparam int unsigned T_W  = DIV_W + 7;
  localparam int unsigned PL_W = $clog2(MIN_PULSE + 1);

  ab_state_e        state_q, state_d;
  logic             rx_s1_q, rx_s2_q, rx_prev_q;
  logic [PL_W-1:0]  idle_cnt_q, idle_cnt_d;
  logic [PL_W-1:0]  pulse_len_q, pulse_len_d;
  logic [2:0]       edge_cnt_q, edge_cnt_d;
  logic [T_W-1:0]   t_q, t_d;
  logic [DIV_W-1:0] divisor_q, divisor_d;
  logic             locked_q, locked_d;
  logic             error_q, error_d;

  logic             rx_sync, level_change, fall_edge;
  logic             idle_done, glitch, t_sat, last_edge;
  logic [T_W:0]     t_round, period;
  logic             period_bad, meas_fail, calc_fail, lock_ok;

  // Condition decode
  assign rx_sync      = rx_s2_q;
  assign level_change = rx_sync ^ rx_prev_q;
  assign fall_edge    = rx_prev_q & ~rx_sync;
  assign idle_done    = rx_sync && (idle_cnt_q == PL_W'(MIN_PULSE - 1));
  assign glitch       = level_change && (pulse_len_q < PL_W'(MIN_PULSE));
  assign t_sat        = &t_q;
  // The first edge is consumed by WAIT_EDGE, so SYNC_EDGES-2 prior edges here.
  assign last_edge    = fall_edge && (edge_cnt_q == 3'(SYNC_EDGES - 2));

  // T spans 8 bit-times = 128 ticks; round(T/128) is the tick period.
  assign t_round    = {1'b0, t_q} + (T_W + 1)'(ROUND_ADD);
  assign period     = t_round >> OVERSAMPLE_SHIFT;
  assign period_bad = (period < (T_W + 1)'(2)) ||
                      (period > ((T_W + 1)'(1) << DIV_W));

  assign meas_fail = (state_q == ST_MEASURE) && (glitch || t_sat);
  assign calc_fail = (state_q == ST_CALC) && period_bad;
  assign lock_ok   = (state_q == ST_CALC) && !period_bad;

  // State register and datapath flops
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      rx_prev_q   <= 1'b1;
      idle_cnt_q  <= '0;
      pulse_len_q <= '0;
      edge_cnt_q  <= '0;
      t_q         <= '0;
      divisor_q   <= DIV_W'(DEFAULT_DIV);
      locked_q    <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_s1_q     <= rx;
      rx_s2_q     <= rx_s1_q;
      rx_prev_q   <= rx_s2_q;
      idle_cnt_q  <= idle_cnt_d;
      pulse_len_q <= pulse_len_d;
      edge_cnt_q  <= edge_cnt_d;
      t_q         <= t_d;
      divisor_q   <= divisor_d;
      locked_q    <= locked_d;
      error_q     <= error_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:      if (start)              state_d = ST_WAIT_IDLE;
      ST_WAIT_IDLE: if (idle_done)          state_d = ST_WAIT_EDGE;
      ST_WAIT_EDGE: if (fall_edge)          state_d = ST_MEASURE;
      ST_MEASURE: begin
        if (glitch || t_sat)                state_d = ST_IDLE;
        else if (last_edge)                 state_d = ST_CALC;
      end
      ST_CALC:                              state_d = ST_IDLE;
      default:                              state_d = ST_IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    idle_cnt_d  = '0;
    pulse_len_d = pulse_len_q;
    edge_cnt_d  = edge_cnt_q;
    t_d         = t_q;
    unique case (state_q)
      ST_WAIT_IDLE: begin
        if (rx_sync && !idle_done) idle_cnt_d = idle_cnt_q + PL_W'(1);
      end
      ST_WAIT_EDGE: begin
        if (fall_edge) begin
          // The edge cycle is the first clock of both T and the low pulse.
          t_d         = T_W'(1);
          pulse_len_d = PL_W'(1);
          edge_cnt_d  = '0;
        end
      end
      ST_MEASURE: begin
        t_d = t_sat ? t_q : t_q + T_W'(1);
        if (level_change)                         pulse_len_d = PL_W'(1);
        else if (pulse_len_q < PL_W'(MIN_PULSE))  pulse_len_d = pulse_len_q + PL_W'(1);
        if (fall_edge)                            edge_cnt_d  = edge_cnt_q + 3'd1;
      end
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    busy      = (state_q != ST_IDLE);
    error_d   = meas_fail || calc_fail;
    divisor_d = lock_ok ? DIV_W'(period - (T_W + 1)'(1)) : divisor_q;
    locked_d  = locked_q;
    if ((state_q == ST_IDLE) && start) locked_d = 1'b0;
    else if (lock_ok)                  locked_d = 1'b1;
  end

  assign locked  = locked_q;
  assign error   = error_q;
  assign divisor = divisor_q;

  baud_tick_prog #(
    .DIV_W (DIV_W)
  ) u_tick (
    .clock     (clock),
    .reset_n   (reset_n),
    .divisor   (divisor_q),
    .load      (lock_ok),
    .baud_rate (baud_rate)
  );

endmodule
